// File: rtl/sram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_ctrl_pkg
// Description : Shared defaults, controller state type, request record and
//               round-robin helper for the SRAM port arbiter.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package sram_ctrl_pkg;

    localparam int DEF_WIDTH        = 512;
    localparam int DEF_LOG_NUM_ROWS = 9;
    localparam int DEF_WORD_SIZE    = 64;
    localparam int DEF_NW           = DEF_WIDTH / DEF_WORD_SIZE;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } ctrl_state_e;

    typedef struct packed {
        logic                        write;
        logic [DEF_LOG_NUM_ROWS-1:0] addr;
        logic [DEF_WIDTH-1:0]        wdata;
        logic [DEF_NW-1:0]           wmask;
    } sram_req_t;

    // Pointer value that follows a grant to requester g.
    function automatic int rr_next(input int g, input int n);
        return (g + 1) % n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker. Grants the first asserted
//               request at or after ptr, wrapping around.
// Ports       : req [N] requests, ptr start position,
//               gnt [N] one-hot grant, any = a grant was issued
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import sram_ctrl_pkg::*;
#(
    parameter int N = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          any
);

    // Outer loop walks the priority order starting at ptr; the inner loop only
    // selects which position that step refers to, so all indexing stays on
    // loop constants.
    always_comb begin
        gnt = '0;
        any = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!any && req[i] && (((int'(ptr) + k) % N) == i)) begin
                    gnt[i] = 1'b1;
                    any    = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter
// Description : Shares one 1R/1W SRAM between NUM_REQ requesters. Independent
//               round-robin read and write slots, same-cycle same-row write
//               forwarding into the read response, and the SRAM all-ones
//               initialisation cycle after reset.
// Ports       : clk, reset_n (async, active low)
//               req_valid/req_write/req_addr/req_wdata/req_wmask in, req_ready out
//               rsp_valid (one-hot) and shared rsp_data out
//               sram_reset/sram_readAddr/sram_writeAddr/sram_writeData/
//               sram_writeEnable out, sram_readData in
// Revision    : 1.0 - initial release
// ============================================================================
module sram_arbiter
    import sram_ctrl_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int LOG_NUM_ROWS = DEF_LOG_NUM_ROWS,
    parameter int WORD_SIZE    = DEF_WORD_SIZE,
    parameter int NUM_REQ      = 2,
    localparam int NW = WIDTH / WORD_SIZE
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0]              req_write,
    input  logic [NUM_REQ*LOG_NUM_ROWS-1:0] req_addr,
    input  logic [NUM_REQ*WIDTH-1:0]        req_wdata,
    input  logic [NUM_REQ*NW-1:0]           req_wmask,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [WIDTH-1:0]                rsp_data,
    output logic                            sram_reset,
    output logic [LOG_NUM_ROWS-1:0]         sram_readAddr,
    output logic [LOG_NUM_ROWS-1:0]         sram_writeAddr,
    output logic [WIDTH-1:0]                sram_writeData,
    output logic [NW-1:0]                   sram_writeEnable,
    input  logic [WIDTH-1:0]                sram_readData
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [0:0] S_INIT = 1'(INIT);
    localparam logic [0:0] S_RUN  = 1'(RUN);

    logic [0:0]              state_q, state_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [LOG_NUM_ROWS-1:0] read_addr_q, read_addr_d;
    logic [NUM_REQ-1:0]      rsp_id_q, rsp_id_d;
    logic [NW-1:0]           fwd_mask_q, fwd_mask_d;
    logic [WIDTH-1:0]        fwd_data_q, fwd_data_d;

    logic                    run;
    logic [NUM_REQ-1:0]      rd_req, wr_req, rd_gnt, wr_gnt;
    logic                    rd_any, wr_any;
    logic [LOG_NUM_ROWS-1:0] rd_addr, wr_addr;
    logic [WIDTH-1:0]        wr_data;
    logic [NW-1:0]           wr_mask;
    int                      rd_idx, wr_idx;
    logic                    fwd_hit;

    // INIT lasts exactly one cycle after reset; RUN is then held.
    always_comb begin
        state_d = S_RUN;
    end

    assign run = (state_q == S_RUN);

    // Gating the candidates in INIT keeps every ready and write enable low.
    assign rd_req = run ? (req_valid & ~req_write) : '0;
    assign wr_req = run ? (req_valid &  req_write) : '0;

    rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
        .req (rd_req),
        .ptr (rd_ptr_q),
        .gnt (rd_gnt),
        .any (rd_any)
    );

    rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
        .req (wr_req),
        .ptr (wr_ptr_q),
        .gnt (wr_gnt),
        .any (wr_any)
    );

    // One-hot grants let the request fields be selected with an OR of masks;
    // no grant yields all zeros (hence a zero write enable).
    always_comb begin
        rd_addr = '0;
        wr_addr = '0;
        wr_data = '0;
        wr_mask = '0;
        rd_idx  = 0;
        wr_idx  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rd_gnt[i]) begin
                rd_addr = rd_addr | req_addr[i*LOG_NUM_ROWS +: LOG_NUM_ROWS];
                rd_idx  = i;
            end
            if (wr_gnt[i]) begin
                wr_addr = wr_addr | req_addr[i*LOG_NUM_ROWS +: LOG_NUM_ROWS];
                wr_data = wr_data | req_wdata[i*WIDTH +: WIDTH];
                wr_mask = wr_mask | req_wmask[i*NW +: NW];
                wr_idx  = i;
            end
        end
    end

    assign req_ready = rd_gnt | wr_gnt;

    assign rd_ptr_d = rd_any ? PW'(rr_next(rd_idx, NUM_REQ)) : rd_ptr_q;
    assign wr_ptr_d = wr_any ? PW'(rr_next(wr_idx, NUM_REQ)) : wr_ptr_q;

    // The read address is sticky so the SRAM read port does not toggle on idle cycles.
    assign sram_readAddr    = rd_any ? rd_addr : read_addr_q;
    assign read_addr_d      = sram_readAddr;
    assign sram_writeAddr   = wr_addr;
    assign sram_writeData   = wr_data;
    assign sram_writeEnable = wr_mask;
    assign sram_reset       = ~run;

    // The SRAM returns the pre-write row on a same-cycle collision, so the
    // written words are captured here and patched into the response.
    assign fwd_hit    = rd_any & wr_any & (wr_addr == rd_addr);
    assign fwd_mask_d = fwd_hit ? wr_mask : '0;
    assign fwd_data_d = fwd_hit ? wr_data : fwd_data_q;
    assign rsp_id_d   = rd_gnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_INIT;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            read_addr_q <= '0;
            rsp_id_q    <= '0;
            fwd_mask_q  <= '0;
            fwd_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            read_addr_q <= read_addr_d;
            rsp_id_q    <= rsp_id_d;
            fwd_mask_q  <= fwd_mask_d;
            fwd_data_q  <= fwd_data_d;
        end
    end

    assign rsp_valid = rsp_id_q;

    generate
        for (genvar w = 0; w < NW; w++) begin : g_rsp_word
            assign rsp_data[w*WORD_SIZE +: WORD_SIZE] = fwd_mask_q[w]
                ? fwd_data_q[w*WORD_SIZE +: WORD_SIZE]
                : sram_readData[w*WORD_SIZE +: WORD_SIZE];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_arbiter
// Description : Self-checking bench for sram_arbiter with an SRAM behaviour
//               model attached. Directed vector table, hand-written reset
//               sequences and randomized traffic against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;

    localparam int W  = 512;
    localparam int L  = 9;
    localparam int WS = 64;
    localparam int NW = W / WS;
    localparam int N  = 2;
    localparam int ROWS = 1 << L;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   req_valid, req_write;
    logic [N*L-1:0] req_addr;
    logic [N*W-1:0] req_wdata;
    logic [N*NW-1:0] req_wmask;
    logic [N-1:0]   req_ready, rsp_valid;
    logic [W-1:0]   rsp_data;
    logic           sram_reset;
    logic [L-1:0]   sram_readAddr, sram_writeAddr;
    logic [W-1:0]   sram_writeData;
    logic [NW-1:0]  sram_writeEnable;
    logic [W-1:0]   sram_readData;

    always #5 clk = ~clk;

    sram_arbiter #(
        .WIDTH(W), .LOG_NUM_ROWS(L), .WORD_SIZE(WS), .NUM_REQ(N)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wmask(req_wmask), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .sram_reset(sram_reset), .sram_readAddr(sram_readAddr),
        .sram_writeAddr(sram_writeAddr), .sram_writeData(sram_writeData),
        .sram_writeEnable(sram_writeEnable), .sram_readData(sram_readData)
    );

    // SRAM macro behaviour: synchronous all-ones reset, word write enables,
    // registered read returning the row as it was before the same-edge write.
    logic [W-1:0] sram_mem [0:ROWS-1];
    always @(posedge clk) begin
        if (sram_reset) begin
            for (int r = 0; r < ROWS; r++) sram_mem[r] <= '1;
        end else begin
            for (int w = 0; w < NW; w++)
                if (sram_writeEnable[w])
                    sram_mem[sram_writeAddr][w*WS +: WS] <= sram_writeData[w*WS +: WS];
        end
        sram_readData <= sram_mem[sram_readAddr];
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: the SRAM contents as a sparse map (absent row = all ones),
    // and the two round-robin pointers as plain integers.
    logic [W-1:0] gold [int];
    int m_rd_ptr, m_wr_ptr;
    bit m_run;

    function automatic logic [W-1:0] gold_rd(input int row);
        if (gold.exists(row)) return gold[row];
        return '1;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] cand, input int ptr);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (ptr + k) % N;
            if (((cand >> idx) & N'(1)) != '0) return idx;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int g);
        if (g < 0) return '0;
        return N'(1) << g;
    endfunction

    typedef struct {
        logic [N-1:0]  valid, write;
        logic [L-1:0]  a0, a1;
        logic [W-1:0]  d0, d1;
        logic [NW-1:0] m0, m1;
        logic [N-1:0]  exp_ready, exp_rv;
        logic [W-1:0]  exp_data;
        bit            use_tab;
    } vec_t;

    function automatic vec_t mk(input logic [N-1:0] valid, input logic [N-1:0] write,
                                input logic [L-1:0] a0, input logic [L-1:0] a1,
                                input logic [WS-1:0] w0, input logic [WS-1:0] w1,
                                input logic [NW-1:0] m0, input logic [NW-1:0] m1,
                                input logic [N-1:0] er, input logic [N-1:0] erv,
                                input logic [W-1:0] ed);
        vec_t v;
        v.valid = valid; v.write = write; v.a0 = a0; v.a1 = a1;
        v.d0 = {NW{w0}}; v.d1 = {NW{w1}}; v.m0 = m0; v.m1 = m1;
        v.exp_ready = er; v.exp_rv = erv; v.exp_data = ed; v.use_tab = 1'b1;
        return v;
    endfunction

    function automatic logic [W-1:0] rnd_wide();
        logic [W-1:0] r;
        for (int i = 0; i < W/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // One cycle: inputs applied just after the falling edge, ready and write
    // enable sampled 1 ns later, response sampled 1 ns after the rising edge.
    task automatic step(input vec_t v);
        logic [N-1:0]  rdc, wrc, exp_ready, exp_rv;
        logic [NW-1:0] exp_we, msk;
        logic [W-1:0]  exp_data, row_val, dat;
        int rg, wg, row;
        req_valid = v.valid; req_write = v.write;
        req_addr  = {v.a1, v.a0};
        req_wdata = {v.d1, v.d0};
        req_wmask = {v.m1, v.m0};
        #1;
        rdc = m_run ? (v.valid & ~v.write) : '0;
        wrc = m_run ? (v.valid &  v.write) : '0;
        rg  = rr_pick(rdc, m_rd_ptr);
        wg  = rr_pick(wrc, m_wr_ptr);
        exp_ready = onehot(rg) | onehot(wg);
        msk = (wg == 1) ? v.m1 : v.m0;
        exp_we = (wg >= 0) ? msk : '0;
        chk("ready", W'(req_ready), W'(exp_ready));
        chk("write_enable", W'(sram_writeEnable), W'(exp_we));
        if (v.use_tab) chk("tab_ready", W'(req_ready), W'(v.exp_ready));
        if (!m_run) chk("init_sram_reset", W'(sram_reset), W'(1'b1));
        // A read sees the memory as it stands after the same-cycle write.
        if (wg >= 0) begin
            row = (wg == 1) ? int'(v.a1) : int'(v.a0);
            dat = (wg == 1) ? v.d1 : v.d0;
            row_val = gold_rd(row);
            for (int w = 0; w < NW; w++)
                if (msk[w]) row_val[w*WS +: WS] = dat[w*WS +: WS];
            gold[row] = row_val;
            m_wr_ptr = (wg + 1) % N;
        end
        exp_rv = onehot(rg);
        exp_data = '0;
        if (rg >= 0) begin
            exp_data = gold_rd((rg == 1) ? int'(v.a1) : int'(v.a0));
            m_rd_ptr = (rg + 1) % N;
        end
        if (!m_run) begin
            gold.delete();
            m_run = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("rsp_valid", W'(rsp_valid), W'(exp_rv));
        if (exp_rv != '0) chk("rsp_data", rsp_data, exp_data);
        if (v.use_tab) begin
            chk("tab_rsp_valid", W'(rsp_valid), W'(v.exp_rv));
            if (v.exp_rv != '0) chk("tab_rsp_data", rsp_data, v.exp_data);
        end
        @(negedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset_n  = 1'b1;
        m_run    = 1'b0;
        m_rd_ptr = 0;
        m_wr_ptr = 0;
    endtask

    localparam logic [WS-1:0] ONES64 = '1;
    localparam logic [W-1:0]  ONES   = '1;

    vec_t vecs[$];

    initial begin
        vec_t v;
        reset_n   = 1'b0;
        req_valid = 2'b11;
        req_write = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        req_wmask = '0;

        // Outputs while reset is held.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sram_reset", W'(sram_reset), W'(1'b1));
        chk("rst_ready", W'(req_ready), W'(0));
        chk("rst_write_enable", W'(sram_writeEnable), W'(0));
        chk("rst_rsp_valid", W'(rsp_valid), W'(0));
        chk("rst_read_addr", W'(sram_readAddr), W'(0));
        reset_n  = 1'b1;
        m_run    = 1'b0;
        m_rd_ptr = 0;
        m_wr_ptr = 0;

        //                 valid  write  a0  a1  w0             w1             m0     m1     rdy    rv     data
        vecs.push_back(mk(2'b11, 2'b00, 5,  5,  64'h0,         64'h0,         8'h00, 8'h00, 2'b00, 2'b00, '0));
        vecs.push_back(mk(2'b01, 2'b00, 5,  0,  64'h0,         64'h0,         8'h00, 8'h00, 2'b01, 2'b01, ONES));
        vecs.push_back(mk(2'b11, 2'b01, 3,  3,  64'hA5,        64'h0,         8'hFF, 8'h00, 2'b11, 2'b10, {NW{64'hA5}}));
        vecs.push_back(mk(2'b11, 2'b10, 7,  7,  64'h0,         64'h1234,      8'h00, 8'h01, 2'b11, 2'b01, {{7{ONES64}}, 64'h1234}));
        vecs.push_back(mk(2'b10, 2'b00, 0,  3,  64'h0,         64'h0,         8'h00, 8'h00, 2'b10, 2'b10, {NW{64'hA5}}));
        for (int i = 0; i < 6; i++)
            vecs.push_back(mk(2'b11, 2'b00, 10, 11, 64'h0,     64'h0,         8'h00, 8'h00,
                              (i % 2 == 0) ? 2'b01 : 2'b10, (i % 2 == 0) ? 2'b01 : 2'b10, ONES));
        vecs.push_back(mk(2'b01, 2'b01, 9,  0,  64'hC3,        64'h0,         8'hFF, 8'h00, 2'b01, 2'b00, '0));
        vecs.push_back(mk(2'b10, 2'b00, 0,  9,  64'h0,         64'h0,         8'h00, 8'h00, 2'b10, 2'b10, {NW{64'hC3}}));
        vecs.push_back(mk(2'b11, 2'b10, 9,  9,  64'h0,         64'h0,         8'h00, 8'h00, 2'b11, 2'b01, {NW{64'hC3}}));
        vecs.push_back(mk(2'b11, 2'b11, 12, 13, 64'h1111,      64'h2222,      8'hFF, 8'hFF, 2'b01, 2'b00, '0));
        vecs.push_back(mk(2'b11, 2'b11, 12, 13, 64'h1111,      64'h2222,      8'hFF, 8'hFF, 2'b10, 2'b00, '0));
        vecs.push_back(mk(2'b11, 2'b00, 13, 12, 64'h0,         64'h0,         8'h00, 8'h00, 2'b10, 2'b10, {NW{64'h1111}}));

        foreach (vecs[i]) step(vecs[i]);

        // Reset arriving while a read response is on the bus.
        req_valid = 2'b01; req_write = 2'b00;
        req_addr  = {L'(0), L'(3)};
        req_wmask = '0;
        #1;
        chk("mid_ready", W'(req_ready), W'(2'b01));
        @(posedge clk);
        #1;
        chk("mid_rsp_before_reset", W'(rsp_valid), W'(2'b01));
        reset_n = 1'b0;
        #1;
        chk("mid_rsp_async_clear", W'(rsp_valid), W'(0));
        chk("mid_sram_reset", W'(sram_reset), W'(1'b1));
        req_valid = '0;
        repeat (2) @(posedge clk);
        release_reset();
        step(mk(2'b01, 2'b00, 3, 0, 64'h0, 64'h0, 8'h00, 8'h00, 2'b00, 2'b00, '0));
        step(mk(2'b01, 2'b00, 3, 0, 64'h0, 64'h0, 8'h00, 8'h00, 2'b01, 2'b01, ONES));

        // Randomized traffic on a handful of rows so collisions are frequent.
        for (int n = 0; n < 400; n++) begin
            v.valid = N'($urandom);
            v.write = N'($urandom);
            v.a0    = L'($urandom_range(0, 3));
            v.a1    = L'($urandom_range(0, 3));
            v.d0    = rnd_wide();
            v.d1    = rnd_wide();
            v.m0    = NW'($urandom);
            v.m1    = NW'($urandom);
            v.exp_ready = '0; v.exp_rv = '0; v.exp_data = '0;
            v.use_tab = 1'b0;
            step(v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
